// File: rtl/simple_datapath_if.sv
// Control/operand and store-port bundle between the SimpleComputer FSM (master)
// and the execution datapath (slave).
interface simple_datapath_if #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4
);
  localparam int AW = $clog2(NREG);

  logic [3:0]       F;
  logic [WIDTH-1:0] imm;
  logic [AW-1:0]    rd;
  logic [AW-1:0]    rs;
  logic [WIDTH-1:0] store_data;
  logic             store_valid;
  logic             store_ready;
  logic             carry;
  logic             zero;
  logic             err;
  logic [15:0]      instr_count;

  modport master (
    output F, imm, rd, rs, store_ready,
    input  store_data, store_valid, carry, zero, err, instr_count
  );

  modport slave (
    input  F, imm, rd, rs, store_ready,
    output store_data, store_valid, carry, zero, err, instr_count
  );
endinterface

// File: rtl/simple_datapath.sv
// Execution datapath: small register file driven by a one-hot control word,
// with ADD flags, a valid/ready store port, sticky error and instruction counter.
module simple_datapath #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4
) (
  input  logic            clk,
  input  logic            reset,
  simple_datapath_if.slave bus
);
  localparam logic [3:0] OP_MOVI = 4'b1000;
  localparam logic [3:0] OP_MVD  = 4'b0100;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_STR  = 4'b0001;
  localparam logic [3:0] OP_IDLE = 4'b0000;

  logic [WIDTH-1:0] regs [NREG];
  logic [WIDTH:0]   sum;
  logic             drained;
  logic             slot_free;

  always_comb begin
    sum       = {1'b0, regs[bus.rd]} + {1'b0, regs[bus.rs]};
    drained   = bus.store_valid && bus.store_ready;
    slot_free = !bus.store_valid || bus.store_ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the register file is small and must read zero out of reset, so it
      // is reset in place rather than mapped onto a RAM macro.
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      bus.store_data  <= '0;
      bus.store_valid <= 1'b0;
      bus.carry       <= 1'b0;
      bus.zero        <= 1'b0;
      bus.err         <= 1'b0;
      bus.instr_count <= '0;
    end else begin
      // A completed transfer frees the slot; an accepted STR below re-fills it.
      if (drained) bus.store_valid <= 1'b0;

      unique case (bus.F)
        OP_MOVI: begin
          regs[bus.rd]    <= bus.imm;
          bus.instr_count <= bus.instr_count + 16'd1;
        end
        OP_MVD: begin
          regs[bus.rd]    <= regs[bus.rs];
          bus.instr_count <= bus.instr_count + 16'd1;
        end
        OP_ADD: begin
          regs[bus.rd]    <= sum[WIDTH-1:0];
          bus.carry       <= sum[WIDTH];
          bus.zero        <= (sum[WIDTH-1:0] == '0);
          bus.instr_count <= bus.instr_count + 16'd1;
        end
        OP_STR: begin
          if (slot_free) begin
            bus.store_data  <= regs[bus.rs];
            bus.store_valid <= 1'b1;
          end else begin
            bus.err <= 1'b1;
          end
          bus.instr_count <= bus.instr_count + 16'd1;
        end
        OP_IDLE: ;
        default: bus.err <= 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_simple_datapath.sv
// Directed and randomized bench for simple_datapath against a behavioural model.
module tb_simple_datapath;
  localparam int WIDTH = 8;
  localparam int NREG  = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  simple_datapath_if #(.WIDTH(WIDTH), .NREG(NREG)) bus ();

  simple_datapath #(.WIDTH(WIDTH), .NREG(NREG)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Behavioural reference state
  int unsigned m_r [NREG];
  int unsigned m_data;
  bit          m_valid, m_carry, m_zero, m_err;
  int unsigned m_cnt;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".store_data"},  32'(bus.store_data),  m_data);
    check({tag, ".store_valid"}, 32'(bus.store_valid), 32'(m_valid));
    check({tag, ".carry"},       32'(bus.carry),       32'(m_carry));
    check({tag, ".zero"},        32'(bus.zero),        32'(m_zero));
    check({tag, ".err"},         32'(bus.err),         32'(m_err));
    check({tag, ".instr_count"}, 32'(bus.instr_count), m_cnt);
    for (int i = 0; i < NREG; i++)
      check($sformatf("%s.R%0d", tag, i), 32'(dut.regs[i]), m_r[i]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_r[i] = 0;
    m_data = 0; m_valid = 0; m_carry = 0; m_zero = 0; m_err = 0; m_cnt = 0;
  endtask

  // Apply one instruction per the operation rules, using pre-edge values.
  task automatic model_step(input logic [3:0] f, input int unsigned imm,
                            input int unsigned rd, input int unsigned rs, input bit ready);
    int unsigned s;
    bit old_valid;
    old_valid = m_valid;
    if (m_valid && ready) m_valid = 0;
    if ($countones(f) > 1) begin
      m_err = 1;
    end else if (f == 4'b1000) begin
      m_r[rd] = imm;
    end else if (f == 4'b0100) begin
      m_r[rd] = m_r[rs];
    end else if (f == 4'b0010) begin
      s = m_r[rd] + m_r[rs];
      m_r[rd] = s % 256;
      m_carry = (s > 255);
      m_zero  = ((s % 256) == 0);
    end else if (f == 4'b0001) begin
      if (!old_valid || ready) begin
        m_data  = m_r[rs];
        m_valid = 1;
      end else begin
        m_err = 1;
      end
    end
    if ($countones(f) == 1) m_cnt = (m_cnt + 1) % 65536;
  endtask

  // Drive inputs, take one edge, update model, optionally compare 1 time unit later.
  task automatic step(input string tag, input logic [3:0] f, input logic [7:0] imm,
                      input logic [1:0] rd, input logic [1:0] rs, input bit ready,
                      input bit chk);
    bus.F = f; bus.imm = imm; bus.rd = rd; bus.rs = rs; bus.store_ready = ready;
    @(posedge clk);
    model_step(f, imm, rd, rs, ready);
    #1;
    if (chk) check_all(tag);
  endtask

  logic [3:0] rf;
  logic [7:0] rimm;
  logic [1:0] rrd, rrs;
  bit         rrdy;

  initial begin
    bus.F = 4'b0000; bus.imm = '0; bus.rd = '0; bus.rs = '0; bus.store_ready = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: MOVI, MOVI, ADD without carry
    step("t1.movi1", 4'b1000, 8'h05, 2'd1, 2'd0, 1'b0, 1'b1);
    step("t1.movi2", 4'b1000, 8'h03, 2'd2, 2'd0, 1'b0, 1'b1);
    step("t1.add",   4'b0010, 8'h00, 2'd1, 2'd2, 1'b0, 1'b1);
    check("t1.R1_const", 32'(dut.regs[1]), 32'h08);
    check("t1.count_const", 32'(bus.instr_count), 32'd3);

    // 2: ADD with carry out and zero result, then MVD
    step("t2.movi0", 4'b1000, 8'hFF, 2'd0, 2'd0, 1'b0, 1'b1);
    step("t2.movi3", 4'b1000, 8'h01, 2'd3, 2'd0, 1'b0, 1'b1);
    step("t2.add",   4'b0010, 8'h00, 2'd0, 2'd3, 1'b0, 1'b1);
    check("t2.carry_const", 32'(bus.carry), 32'd1);
    check("t2.zero_const",  32'(bus.zero),  32'd1);
    step("t2.mvd",   4'b0100, 8'h00, 2'd2, 2'd0, 1'b0, 1'b1);

    // 3: store held under back-pressure, then drained
    step("t3.str",   4'b0001, 8'h00, 2'd0, 2'd1, 1'b0, 1'b1);
    check("t3.data_const", 32'(bus.store_data), 32'h08);
    for (int i = 0; i < 3; i++) step("t3.hold", 4'b0000, 8'h00, 2'd0, 2'd0, 1'b0, 1'b1);
    step("t3.drain", 4'b0000, 8'h00, 2'd0, 2'd0, 1'b1, 1'b1);

    // 4: dropped store sets err; drain plus new STR on the same edge
    step("t4.str",   4'b0001, 8'h00, 2'd0, 2'd1, 1'b0, 1'b1);
    step("t4.drop",  4'b0001, 8'h00, 2'd0, 2'd2, 1'b0, 1'b1);
    step("t4.swap",  4'b0001, 8'h00, 2'd0, 2'd0, 1'b1, 1'b1);

    // 5: multi-hot, idle, counter wrap with random legal ops
    step("t5.multihot", 4'b1100, 8'h77, 2'd1, 2'd2, 1'b0, 1'b1);
    step("t5.idle",     4'b0000, 8'h55, 2'd1, 2'd2, 1'b0, 1'b1);
    for (int i = 0; i < 65536; i++) begin
      rf   = 4'b0001 << $urandom_range(0, 3);
      rimm = 8'($urandom); rrd = 2'($urandom); rrs = 2'($urandom); rrdy = 1'($urandom);
      step("t5.wrap", rf, rimm, rrd, rrs, rrdy, (i % 8192) == 8191);
    end
    check("t5.wrapped_count", 32'(bus.instr_count), 32'(m_cnt));

    // Random mix including idle and multi-hot codes, checked every edge
    for (int i = 0; i < 300; i++) begin
      rf   = 4'($urandom_range(0, 15));
      rimm = 8'($urandom); rrd = 2'($urandom); rrs = 2'($urandom); rrdy = 1'($urandom);
      step("rand", rf, rimm, rrd, rrs, rrdy, 1'b1);
    end

    // 6: asynchronous reset between edges with a pending store
    step("t6.movi", 4'b1000, 8'h42, 2'd1, 2'd0, 1'b0, 1'b1);
    step("t6.str",  4'b0001, 8'h00, 2'd0, 2'd1, 1'b0, 1'b1);
    bus.F = 4'b0000;
    #2 reset = 1'b0;
    model_reset();
    #1;
    check_all("t6.async");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    step("t6.str0", 4'b0001, 8'h00, 2'd0, 2'd1, 1'b0, 1'b1);
    check("t6.data_const", 32'(bus.store_data), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
